pll_reset_supervisor: RTL and testbench



---
 rtl/pll_sup_pkg.sv | 17 +
 rtl/sync_2ff.sv | 29 ++
 rtl/pll_reset_supervisor.sv | 157 +++++++++++++++
 tb/tb_pll_reset_supervisor.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL reset supervisor.
//   pll_sup_state_e : supervisor state encoding. It is also the value
//                     reported on state_o and in the debug status register.
//   LossCntW        : width of the saturating lock-loss counter.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        StHold     = 3'd0,
        StWaitLock = 3'd1,
        StSettle   = 3'd2,
        StRun      = 3'd3,
        StFail     = 3'd4
    } pll_sup_state_e;

    localparam int unsigned LossCntW = 8;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit double-flop synchroniser for asynchronous status inputs.
// Ports:
//   i_clk   : destination clock
//   i_rst_n : synchronous active-low reset; both flops clear to 0
//   i_d     : asynchronous input
//   o_q     : synchronised output, two i_clk edges behind i_d
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_supervisor.sv
// PLL reset supervisor. This block drives the PLL reset and waits for lock,
// with a timeout and a retry limit. It checks that lock stays stable, then
// releases the system reset. It re-sequences the PLL on lock loss or on a
// soft reset request.
// Ports:
//   refclk        : reference clock, the only clock
//   rst_n         : synchronous active-low reset
//   pll_locked    : PLL lock, asynchronous to refclk
//   soft_reset    : level request to re-sequence the PLL
//   pll_rst       : PLL reset, active high (high only in HOLD)
//   sys_reset_n   : system reset, active low (high only in RUN)
//   fail          : failure flag (high only in FAIL)
//   lock_loss_cnt : saturating count of lock losses seen in RUN
//   state_o       : current state encoding
module pll_reset_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned CW            = 16
) (
    input  logic                refclk,
    input  logic                rst_n,
    input  logic                pll_locked,
    input  logic                soft_reset,
    output logic                pll_rst,
    output logic                sys_reset_n,
    output logic                fail,
    output logic [LossCntW-1:0] lock_loss_cnt,
    output logic [2:0]          state_o
);

    localparam int unsigned RW = $clog2(MAX_RETRY + 1);

    localparam logic [CW-1:0] RstLast    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] LockLast   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SettleLast = CW'(SETTLE_CYCLES - 1);
    localparam logic [RW-1:0] RetryMax   = RW'(MAX_RETRY);

    pll_sup_state_e      r_state;
    pll_sup_state_e      w_state_d;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_d;
    logic [RW-1:0]       r_retry;
    logic [RW-1:0]       w_retry_d;
    logic [RW-1:0]       w_retry_inc;
    logic [LossCntW-1:0] r_loss_cnt;
    logic [LossCntW-1:0] w_loss_cnt_d;
    logic                r_pll_rst;
    logic                r_sys_reset_n;
    logic                r_fail;
    logic                w_locked_s;

    sync_2ff u_lock_sync (
        .i_clk   (refclk),
        .i_rst_n (rst_n),
        .i_d     (pll_locked),
        .o_q     (w_locked_s)
    );

    assign w_retry_inc = r_retry + 1'b1;

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt + 1'b1;
        w_retry_d    = r_retry;
        w_loss_cnt_d = r_loss_cnt;

        // A soft reset wins over every other transition. It masks a lock
        // drop that happens in the same cycle, so that drop is not counted.
        if (soft_reset) begin
            w_state_d = StHold;
            w_cnt_d   = '0;
            if (r_state == StFail) begin
                w_retry_d = '0;
            end
        end else begin
            unique case (r_state)
                StHold: begin
                    if (r_cnt == RstLast) begin
                        w_state_d = StWaitLock;
                        w_cnt_d   = '0;
                    end
                end
                StWaitLock: begin
                    if (w_locked_s) begin
                        w_state_d = StSettle;
                        w_cnt_d   = '0;
                    end else if (r_cnt == LockLast) begin
                        w_retry_d = w_retry_inc;
                        w_cnt_d   = '0;
                        w_state_d = (w_retry_inc == RetryMax) ? StFail : StHold;
                    end
                end
                StSettle: begin
                    // A lock glitch while settling restarts the lock wait
                    // but does not count as a retry.
                    if (!w_locked_s) begin
                        w_state_d = StWaitLock;
                        w_cnt_d   = '0;
                    end else if (r_cnt == SettleLast) begin
                        w_state_d = StRun;
                        w_cnt_d   = '0;
                        w_retry_d = '0;
                    end
                end
                StRun: begin
                    w_cnt_d = '0;
                    if (!w_locked_s) begin
                        w_state_d = StHold;
                        if (r_loss_cnt != '1) begin
                            w_loss_cnt_d = r_loss_cnt + 1'b1;
                        end
                    end
                end
                StFail: begin
                    w_cnt_d = '0;
                end
                default: begin
                    w_state_d = StHold;
                    w_cnt_d   = '0;
                end
            endcase
        end
    end

    // The outputs decode the next state, so they change on the same edge
    // as the state register.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            r_state       <= StHold;
            r_cnt         <= '0;
            r_retry       <= '0;
            r_loss_cnt    <= '0;
            r_pll_rst     <= 1'b1;
            r_sys_reset_n <= 1'b0;
            r_fail        <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_cnt         <= w_cnt_d;
            r_retry       <= w_retry_d;
            r_loss_cnt    <= w_loss_cnt_d;
            r_pll_rst     <= (w_state_d == StHold);
            r_sys_reset_n <= (w_state_d == StRun);
            r_fail        <= (w_state_d == StFail);
        end
    end

    assign pll_rst       = r_pll_rst;
    assign sys_reset_n   = r_sys_reset_n;
    assign fail          = r_fail;
    assign lock_loss_cnt = r_loss_cnt;
    assign state_o       = r_state;

endmodule

// File: tb/tb_pll_reset_supervisor.sv
// Directed testbench for pll_reset_supervisor. It uses the reduced timing
// parameters below. Inputs are driven and outputs are sampled on the falling
// edge of refclk.
module tb_pll_reset_supervisor;
    import pll_sup_pkg::*;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       soft_reset;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       fail;
    logic [7:0] lock_loss_cnt;
    logic [2:0] state_o;

    int n_tests;
    int n_fail;

    pll_reset_supervisor #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .SETTLE_CYCLES (8),
        .MAX_RETRY     (2),
        .CW            (16)
    ) dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .soft_reset    (soft_reset),
        .pll_rst       (pll_rst),
        .sys_reset_n   (sys_reset_n),
        .fail          (fail),
        .lock_loss_cnt (lock_loss_cnt),
        .state_o       (state_o)
    );

    initial refclk = 1'b0;
    always #10 refclk = ~refclk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge refclk);
    endtask

    // Steps until state_o equals st or until the limit is reached. Returns
    // the number of cycles taken.
    task automatic wait_state(input logic [2:0] st, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (state_o != st && n < limit);
    endtask

    task automatic lose_and_recover(output bit ok);
        int n;
        ok = 1'b1;
        pll_locked = 1'b0;
        wait_state(StHold, 10, n);
        if (state_o != StHold) ok = 1'b0;
        pll_locked = 1'b1;
        wait_state(StRun, 40, n);
        if (state_o != StRun) ok = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(state_o), 32'(StHold));
        check({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
        check({tag, "_sys_rst_n"}, 32'(sys_reset_n), 32'd0);
        check({tag, "_fail"}, 32'(fail), 32'd0);
        check({tag, "_llc"}, 32'(lock_loss_cnt), 32'd0);
    endtask

    initial begin
        int cyc;
        int bad;
        bit ok;
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        soft_reset = 1'b0;
        repeat (3) step();
        check_reset_outputs("rst");

        // 1: normal bring-up. Lock rises 10 cycles after reset release.
        rst_n = 1'b1;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (pll_rst && cyc < 100);
        check("t1_pll_rst_len", cyc, 4);
        check("t1_wait_state", 32'(state_o), 32'(StWaitLock));
        repeat (6) step();
        pll_locked = 1'b1;
        repeat (2) step();
        check("t1_pre_settle", 32'(state_o), 32'(StWaitLock));
        step();
        check("t1_settle_3edges", 32'(state_o), 32'(StSettle));
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!sys_reset_n && cyc < 100);
        check("t1_settle_len", cyc, 8);
        check("t1_run", 32'(state_o), 32'(StRun));
        check("t1_fail", 32'(fail), 32'd0);

        // 2: no lock. Two retry rounds, then FAIL.
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        repeat (2) step();
        check_reset_outputs("rst2");
        rst_n = 1'b1;
        wait_state(StWaitLock, 100, cyc);
        check("t2_hold1", cyc, 4);
        wait_state(StHold, 100, cyc);
        check("t2_wait1", cyc, 20);
        wait_state(StWaitLock, 100, cyc);
        check("t2_hold2", cyc, 4);
        wait_state(StFail, 100, cyc);
        check("t2_wait2", cyc, 20);
        check("t2_fail", 32'(fail), 32'd1);
        check("t2_pll_rst", 32'(pll_rst), 32'd0);
        check("t2_sys_rst_n", 32'(sys_reset_n), 32'd0);
        pll_locked = 1'b1;
        repeat (10) step();
        check("t2_fail_sticky_state", 32'(state_o), 32'(StFail));
        check("t2_fail_sticky", 32'(fail), 32'd1);

        // 3: one-cycle soft reset pulse from FAIL.
        soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
        check("t3_hold", 32'(state_o), 32'(StHold));
        check("t3_pll_rst", 32'(pll_rst), 32'd1);
        check("t3_fail_clr", 32'(fail), 32'd0);
        wait_state(StWaitLock, 100, cyc);
        check("t3_hold_len", cyc, 4);
        wait_state(StSettle, 100, cyc);
        check("t3_to_settle", cyc, 1);
        wait_state(StRun, 100, cyc);
        check("t3_settle_len", cyc, 8);
        check("t3_sys_rst_n", 32'(sys_reset_n), 32'd1);

        // 4: a one-cycle lock glitch while settling, at settle count 5.
        soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
        wait_state(StWaitLock, 100, cyc);
        wait_state(StSettle, 100, cyc);
        repeat (3) step();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        step();
        check("t4_still_settle", 32'(state_o), 32'(StSettle));
        step();
        check("t4_back_wait", 32'(state_o), 32'(StWaitLock));
        wait_state(StSettle, 100, cyc);
        check("t4_relock", cyc, 1);
        wait_state(StRun, 100, cyc);
        check("t4_full_settle", cyc, 8);

        // 5: three lock losses while in RUN.
        for (int i = 0; i < 3; i++) begin
            pll_locked = 1'b0;
            cyc = 0;
            do begin
                step();
                cyc++;
            end while (sys_reset_n && cyc < 100);
            check("t5_fall_latency", cyc, 3);
            pll_locked = 1'b1;
            wait_state(StRun, 100, cyc);
            check("t5_recover", cyc, 13);
        end
        check("t5_llc3", 32'(lock_loss_cnt), 32'd3);
        check("t5_run", 32'(state_o), 32'(StRun));

        // 6: a soft reset in the same cycle that locked_s falls.
        pll_locked = 1'b0;
        repeat (2) step();
        soft_reset = 1'b1;
        step();
        check("t6_hold", 32'(state_o), 32'(StHold));
        check("t6_llc_masked", 32'(lock_loss_cnt), 32'd3);
        pll_locked = 1'b1;
        repeat (6) step();
        check("t6_soft_held", 32'(state_o), 32'(StHold));
        check("t6_soft_held_rst", 32'(pll_rst), 32'd1);
        soft_reset = 1'b0;
        wait_state(StRun, 100, cyc);
        check("t6_recover", cyc, 13);
        soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
        check("t6_soft_run_llc", 32'(lock_loss_cnt), 32'd3);
        wait_state(StRun, 100, cyc);

        // Counter saturation: 300 losses in total.
        bad = 0;
        for (int i = 0; i < 252; i++) begin
            lose_and_recover(ok);
            if (!ok) bad++;
        end
        check("sat_llc255", 32'(lock_loss_cnt), 32'd255);
        for (int i = 0; i < 45; i++) begin
            lose_and_recover(ok);
            if (!ok) bad++;
        end
        check("sat_llc_hold", 32'(lock_loss_cnt), 32'd255);
        check("sat_loop_timeouts", bad, 0);

        // rst_n asserted while settling.
        soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
        wait_state(StSettle, 100, cyc);
        repeat (2) step();
        check("t6_in_settle", 32'(state_o), 32'(StSettle));
        rst_n = 1'b0;
        step();
        check_reset_outputs("t6_midrst");
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
